mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Main control FSM for the multicycle MIPS CPU. Sequences each instruction through IF/ID/EX/MEM/WB and drives all datapath enables and selects, including the 3-bit next-PC select and PC write enable for the next-PC unit. Waits on a data-memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
opcode  input  6  IR[31:26], from registered IR
funct  input  6  IR[5:0]
mem_ready  input  1  data memory done (MEM state handshake)
ir_we  output  1  latch instruction register
pc_we  output  1  write PC from next-PC unit
npc_sel  output  3  000 PC+4, 001 imm26 jump, 010 GRF (jr), 011 conditional branch (next-PC unit falls back to PC+4 when zero=0)
reg_we  output  1  GRF write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
wd_sel  output  2  00 ALU, 01 mem, 10 PC+4
alu_src  output  1  0 register, 1 extended immediate
alu_op  output  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
ext_op  output  1  0 zero-ext, 1 sign-ext
mem_re  output  1  data memory read request
mem_we  output  1  data memory write request
state  output  3  current state, for debug
instr_done  output  1  one-cycle pulse on the cycle pc_we=1
instret  output  CNT_W  retired-instruction count

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. One state per clk.
- Reset (async): state=IF, instret=0. While reset=1 all enables (ir_we, pc_we, reg_we, mem_re, mem_we, instr_done) forced 0. Selects default 0.
- Decode classes (opcode/funct):
  - R: opcode 000000 with funct 100000 add / 100010 sub
  - JR: opcode 000000, funct 001000
  - ORI 001101; LUI 001111; LW 100011; SW 101011; BEQ 000100; J 000010; JAL 000011
  - Anything else (incl. sll $0 nop) = NOP
- Outputs: combinational from state and opcode/funct. opcode is valid from ID onward.
- IF: ir_we=1 -> ID.
- ID:
  - J: pc_we=1, npc_sel=001 -> IF.
  - JAL: additionally reg_we=1, reg_dst=10, wd_sel=10.
  - JR: pc_we=1, npc_sel=010 -> IF.
  - NOP: pc_we=1, npc_sel=000 -> IF.
  - Others -> EX.
- EX:
  - R: alu_src=0, alu_op add/sub -> WB.
  - ORI: alu_src=1, ext_op=0, alu_op=010 -> WB.
  - LUI: alu_src=1, alu_op=011 -> WB.
  - LW/SW: alu_src=1, ext_op=1, alu_op=000 -> MEM.
  - BEQ: alu_op=001, pc_we=1, npc_sel=011 -> IF. The zero flag is consumed by the next-PC unit, not by this block.
- MEM:
  - LW: mem_re=1. Stay in MEM while mem_ready=0; -> WB when mem_ready=1.
  - SW: mem_we=1. Stay while mem_ready=0. When mem_ready=1: pc_we=1, npc_sel=000 -> IF.
  - mem_re/mem_we stay held every wait cycle; ALU controls stay as in EX so the address is stable.
- WB: reg_we=1, pc_we=1, npc_sel=000 -> IF.
  - R: reg_dst=01, wd_sel=00.
  - ORI/LUI: reg_dst=00, wd_sel=00.
  - LW: reg_dst=00, wd_sel=01.
- Latency, cycles per instruction without memory wait: J/JAL/JR/NOP 2; BEQ 3; R/ORI/LUI/SW 4; LW 5. Each mem_ready=0 cycle adds 1.
- Exactly one pc_we pulse per instruction, always in its final state. instr_done=pc_we.
- instret increments on each pc_we cycle and wraps modulo 2^CNT_W.
- Reset mid-instruction: returns to IF immediately. No partial write is retained, since no enable is asserted during reset.
- mem_ready is ignored outside MEM.

Test Plan:
- Reset held during MEM of LW, mem_ready=0 -> state=0, mem_re=0, instret=0 immediately; after release, first cycle ir_we=1.
- add (opcode 0, funct 0x20) -> states 0,1,2,4 then 0; WB cycle reg_we=1, reg_dst=01, pc_we=1, npc_sel=000; instret=1.
- lw with mem_ready low 3 cycles -> MEM lasts 4 cycles with mem_re=1 throughout; total 8 cycles; WB wd_sel=01.
- beq (0x04) -> 3 cycles; EX cycle pc_we=1, npc_sel=011, alu_op=001, reg_we=0.
- jal (0x03) then jr (funct 0x08) -> each 2 cycles; jal ID: reg_we=1, reg_dst=10, wd_sel=10, npc_sel=001; jr ID: npc_sel=010; instret advances by 2.
- Unknown opcode 0x3F -> NOP: 2 cycles, pc_we=1, npc_sel=000, no reg/mem writes. Preload instret=2^32-1 via a run -> wraps to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Main control FSM for the multicycle MIPS core: steps each instruction through
// IF/ID/EX/MEM/WB, drives datapath enables/selects and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [2:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic             mem_re,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;

  logic is_r, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;
  logic ir_we_raw, pc_we_raw, reg_we_raw, mem_re_raw, mem_we_raw;

  always_comb begin
    is_sub = (opcode == 6'h00) && (funct == 6'h22);
    is_r   = ((opcode == 6'h00) && (funct == 6'h20)) || is_sub;
    is_jr  = (opcode == 6'h00) && (funct == 6'h08);
    is_ori = (opcode == 6'h0d);
    is_lui = (opcode == 6'h0f);
    is_lw  = (opcode == 6'h23);
    is_sw  = (opcode == 6'h2b);
    is_beq = (opcode == 6'h04);
    is_j   = (opcode == 6'h02);
    is_jal = (opcode == 6'h03);
    is_nop = !(is_r || is_jr || is_ori || is_lui || is_lw || is_sw || is_beq || is_j || is_jal);
  end

  always_comb begin
    state_d    = state_q;
    ir_we_raw  = 1'b0;
    pc_we_raw  = 1'b0;
    reg_we_raw = 1'b0;
    mem_re_raw = 1'b0;
    mem_we_raw = 1'b0;
    npc_sel    = 3'b000;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    ext_op     = 1'b0;
    case (state_q)
      StIf: begin
        ir_we_raw = 1'b1;
        state_d   = StId;
      end
      StId: begin
        if (is_j || is_jal) begin
          pc_we_raw = 1'b1;
          npc_sel   = 3'b001;
          state_d   = StIf;
          if (is_jal) begin
            reg_we_raw = 1'b1;
            reg_dst    = 2'b10;
            wd_sel     = 2'b10;
          end
        end else if (is_jr) begin
          pc_we_raw = 1'b1;
          npc_sel   = 3'b010;
          state_d   = StIf;
        end else if (is_nop) begin
          pc_we_raw = 1'b1;
          state_d   = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        state_d = StIf;
        if (is_r) begin
          alu_op  = is_sub ? 3'b001 : 3'b000;
          state_d = StWb;
        end else if (is_ori) begin
          alu_src = 1'b1;
          alu_op  = 3'b010;
          state_d = StWb;
        end else if (is_lui) begin
          alu_src = 1'b1;
          alu_op  = 3'b011;
          state_d = StWb;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          state_d = StMem;
        end else if (is_beq) begin
          // Taken/not-taken is resolved by the next-PC unit from the zero flag.
          alu_op    = 3'b001;
          pc_we_raw = 1'b1;
          npc_sel   = 3'b011;
        end
      end
      StMem: begin
        // Keep the address computation stable for the whole handshake.
        alu_src = 1'b1;
        ext_op  = 1'b1;
        state_d = StIf;
        if (is_lw) begin
          mem_re_raw = 1'b1;
          state_d    = mem_ready ? StWb : StMem;
        end else if (is_sw) begin
          mem_we_raw = 1'b1;
          pc_we_raw  = mem_ready;
          state_d    = mem_ready ? StIf : StMem;
        end
      end
      StWb: begin
        reg_we_raw = 1'b1;
        pc_we_raw  = 1'b1;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        wd_sel     = is_lw ? 2'b01 : 2'b00;
        state_d    = StIf;
      end
      default: state_d = StIf;
    endcase
  end

  // Reset masks every enable so an interrupted instruction leaves no side effect.
  always_comb begin
    ir_we      = ir_we_raw & ~reset;
    pc_we      = pc_we_raw & ~reset;
    reg_we     = reg_we_raw & ~reset;
    mem_re     = mem_re_raw & ~reset;
    mem_we     = mem_we_raw & ~reset;
    instr_done = pc_we;
    state      = state_q;
    instret    = instret_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIf;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule
